// File: rtl/dvi_pkg.sv
// Shared sizing defaults and fetch FSM encoding for the framebuffer fetch arbiter.
// Defaults are 640x480 at 4 bpp with 16-bit words.
package dvi_pkg;

    localparam int unsigned WPL      = 160;
    localparam int unsigned LINES    = 480;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned LB_AW    = 8;
    localparam int unsigned FB_WORDS = LINES * WPL;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fb_fetch_arbiter_if.sv
// Host write port, framebuffer RAM port and line-buffer write port of the fetch arbiter.
// The master modport is the arbiter side; slave is the RAM/host/line-buffer side.
interface fb_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = dvi_pkg::ADDR_W,
    parameter int unsigned DATA_W = dvi_pkg::DATA_W,
    parameter int unsigned LB_AW  = dvi_pkg::LB_AW
);

    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_lb_we;
    logic [LB_AW-1:0]  o_lb_addr;
    logic [DATA_W-1:0] o_lb_wdata;

    modport master (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_lb_we, o_lb_addr, o_lb_wdata
    );

    modport slave (
        output i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_lb_we, o_lb_addr, o_lb_wdata
    );

endinterface

// File: rtl/fb_fetch_arbiter.sv
// Shares one single-port framebuffer RAM between the display line prefetch (absolute
// priority) and a host write port; fetched lines land in a ping-pong line buffer.
module fb_fetch_arbiter #(
    parameter int unsigned WPL    = dvi_pkg::WPL,
    parameter int unsigned LINES  = dvi_pkg::LINES,
    parameter int unsigned ADDR_W = dvi_pkg::ADDR_W,
    parameter int unsigned DATA_W = dvi_pkg::DATA_W,
    parameter int unsigned LB_AW  = dvi_pkg::LB_AW
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_fetch_start,
    input  logic [9:0]          i_fetch_line,
    output logic                o_lb_bank,
    output logic                o_busy,
    output logic                o_overrun,
    fb_fetch_arbiter_if.master  bus
);

    import dvi_pkg::*;

    localparam int unsigned FbWords = LINES * WPL;
    localparam logic [LB_AW-1:0] LastWord = LB_AW'(WPL - 1);

    fetch_state_e      state_q;
    logic [LB_AW-1:0]  k_q;
    logic [ADDR_W-1:0] base_q;
    logic              bank_q;
    logic              lb_we_q;
    logic [LB_AW-1:0]  lb_addr_q;

    logic              line_ok;
    logic [ADDR_W-1:0] line_base;
    logic              wr_ready;
    logic              wr_in_range;

    always_comb begin
        line_ok     = 32'(i_fetch_line) < LINES;
        // Constant multiplier; folds to (line<<7)+(line<<5) for WPL=160.
        line_base   = ADDR_W'(i_fetch_line) * ADDR_W'(WPL);
        wr_ready    = i_rstn && (state_q == StIdle) && !i_fetch_start;
        wr_in_range = 32'(bus.i_wr_addr) < FbWords;
    end

    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        if (state_q == StFetch) begin
            bus.o_mem_en   = 1'b1;
            bus.o_mem_addr = base_q + ADDR_W'(k_q);
        end else if (bus.i_wr_valid && wr_ready && wr_in_range) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_we    = 1'b1;
            bus.o_mem_addr  = bus.i_wr_addr;
            bus.o_mem_wdata = bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            k_q       <= '0;
            base_q    <= '0;
            bank_q    <= 1'b0;
            lb_we_q   <= 1'b0;
            lb_addr_q <= '0;
        end else begin
            lb_we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_fetch_start && line_ok) begin
                        base_q  <= line_base;
                        k_q     <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    lb_we_q   <= 1'b1;
                    lb_addr_q <= k_q;
                    if (k_q == LastWord) begin
                        state_q <= StDrain;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    bank_q  <= ~bank_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM read data is already registered, so it passes straight to the line buffer.
    assign bus.o_lb_we     = lb_we_q;
    assign bus.o_lb_addr   = lb_addr_q;
    assign bus.o_lb_wdata  = lb_we_q ? bus.i_mem_rdata : '0;
    assign bus.o_wr_ready  = wr_ready;

    assign o_lb_bank = bank_q;
    assign o_busy    = state_q != StIdle;
    assign o_overrun = i_fetch_start && (state_q != StIdle);

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Directed bench for fb_fetch_arbiter: line fetches, host contention, overrun,
// out-of-range accesses and reset in the middle of a fetch.
module tb_fb_fetch_arbiter;

    logic       clk         = 1'b0;
    logic       rstn        = 1'b0;
    logic       fetch_start = 1'b0;
    logic [9:0] fetch_line  = '0;
    logic       lb_bank;
    logic       busy;
    logic       overrun;

    int   n_vec    = 0;
    int   n_err    = 0;
    int   hj       = 0;
    logic hv       = 1'b0;
    logic exp_bank = 1'b0;

    always #5 clk = ~clk;

    fb_fetch_arbiter_if bus ();

    fb_fetch_arbiter dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_fetch_start (fetch_start),
        .i_fetch_line  (fetch_line),
        .o_lb_bank     (lb_bank),
        .o_busy        (busy),
        .o_overrun     (overrun),
        .bus           (bus.master)
    );

    // RAM model: a read returns the low 16 bits of its address one cycle later.
    always @(posedge clk) begin
        if (bus.o_mem_en && !bus.o_mem_we) begin
            bus.i_mem_rdata <= bus.o_mem_addr[15:0];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input int ln);
        fetch_start    = st;
        fetch_line     = 10'(ln);
        bus.i_wr_valid = hv;
        bus.i_wr_addr  = 17'(1000 + hj);
        bus.i_wr_data  = 16'(16'hA000 + hj);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle; when the host stream is on, its next word must reach the RAM.
    task automatic idle_cyc();
        drive(1'b0, 0);
        @(negedge clk);
        check_eq("idle_busy", 64'({busy, overrun, bus.o_lb_we}), 64'(0));
        check_eq("idle_rdy", 64'(bus.o_wr_ready), 64'(1));
        if (hv) begin
            check_eq("host_wr",
                     64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}),
                     64'({2'b11, 17'(1000 + hj), 16'(16'hA000 + hj)}));
            hj++;
        end else begin
            check_eq("idle_mem", 64'(bus.o_mem_en), 64'(0));
        end
        adv();
    endtask

    task automatic do_fetch(input int line, input int ovr_at);
        int base;
        base = line * 160;
        drive(1'b1, line);
        @(negedge clk);
        check_eq("start_busy", 64'({busy, overrun}), 64'(0));
        check_eq("start_rdy", 64'(bus.o_wr_ready), 64'(0));
        check_eq("start_mem", 64'(bus.o_mem_en), 64'(0));
        adv();
        for (int i = 1; i <= 161; i++) begin
            drive(i == ovr_at, 5);
            @(negedge clk);
            check_eq("f_busy", 64'(busy), 64'(1));
            check_eq("f_rdy", 64'(bus.o_wr_ready), 64'(0));
            check_eq("f_ovr", 64'(overrun), 64'(i == ovr_at));
            check_eq("f_bank", 64'(lb_bank), 64'(exp_bank));
            if (i <= 160) begin
                check_eq("rd", 64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr}),
                         64'({2'b10, 17'(base + i - 1)}));
            end else begin
                check_eq("drain_mem", 64'(bus.o_mem_en), 64'(0));
            end
            if (i >= 2) begin
                check_eq("lb", 64'({bus.o_lb_we, bus.o_lb_addr, bus.o_lb_wdata}),
                         64'({1'b1, 8'(i - 2), 16'(base + i - 2)}));
            end else begin
                check_eq("lb_first", 64'(bus.o_lb_we), 64'(0));
            end
            adv();
        end
        exp_bank = ~exp_bank;
        drive(1'b0, 0);
        @(negedge clk);
        check_eq("end_state", 64'({busy, bus.o_lb_we, lb_bank}), 64'({2'b00, exp_bank}));
        adv();
    endtask

    initial begin
        // Reset: host request and fetch start both asserted must be ignored.
        hv = 1'b1;
        drive(1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outs", 64'({busy, lb_bank, overrun, bus.o_lb_we, bus.o_lb_addr}), 64'(0));
        check_eq("rst_rdy_mem", 64'({bus.o_wr_ready, bus.o_mem_en}), 64'(0));
        @(posedge clk);
        #1;
        hv = 1'b0;
        drive(1'b0, 0);
        rstn = 1'b1;
        idle_cyc();

        // Line 0, then the last line, then an out-of-range line.
        do_fetch(0, -1);
        idle_cyc();
        do_fetch(479, -1);
        drive(1'b1, 480);
        @(negedge clk);
        check_eq("l480_start", 64'({busy, overrun, bus.o_mem_en, bus.o_wr_ready}), 64'(0));
        adv();
        drive(1'b0, 0);
        @(negedge clk);
        check_eq("l480_after", 64'({busy, bus.o_mem_en, lb_bank}), 64'({2'b00, exp_bank}));
        adv();

        // Host stream contending with a fetch.
        hv = 1'b1;
        hj = 0;
        repeat (5) idle_cyc();
        do_fetch(10, -1);
        repeat (5) idle_cyc();
        hv = 1'b0;

        // Overrun 50 cycles into a fetch.
        do_fetch(20, 50);
        idle_cyc();

        // Out-of-range host write is accepted but dropped; last valid address is written.
        drive(1'b0, 0);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 17'd76800;
        bus.i_wr_data  = 16'h5A5A;
        @(negedge clk);
        check_eq("oor_rdy", 64'(bus.o_wr_ready), 64'(1));
        check_eq("oor_mem", 64'(bus.o_mem_en), 64'(0));
        adv();
        bus.i_wr_addr = 17'd76799;
        @(negedge clk);
        check_eq("edge_wr", 64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr}),
                 64'({2'b11, 17'd76799}));
        adv();
        bus.i_wr_valid = 1'b0;

        // Reset at word 80 of a fetch with bank=1, then a clean fetch.
        do_fetch(1, -1);
        drive(1'b1, 3);
        adv();
        for (int i = 1; i <= 80; i++) begin
            drive(1'b0, 0);
            adv();
        end
        check_eq("pre_rst_addr", 64'(bus.o_mem_addr), 64'(3 * 160 + 80));
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_outs", 64'({busy, lb_bank, overrun, bus.o_lb_we, bus.o_lb_addr,
                                      bus.o_lb_wdata, bus.o_wr_ready, bus.o_mem_en}), 64'(0));
        exp_bank = 1'b0;
        adv();
        rstn = 1'b1;
        idle_cyc();
        do_fetch(7, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_fetch_arbiter.md
Name: fb_fetch_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: the display line prefetch and a host write port.
- On each horizontal-blanking start from the timing generator, fetches the next display line (WPL words) into a ping-pong line buffer.
- The display line prefetch has absolute priority over the host write port.
- The host write port gets every RAM cycle the fetch does not use.
- Default sizing, 640x480 at 4 bpp: 16-bit words, 160 words per line. This equals the 160-cycle horizontal blank, so a fetch fits exactly.

Parameters:
- WPL, 160, framebuffer words per display line.
- LINES, 480, active lines; highest valid line is LINES-1.
- ADDR_W, 17, RAM word address width; must satisfy LINES*WPL <= 2^ADDR_W.
- DATA_W, 16, RAM and line-buffer word width.
- LB_AW, 8, line-buffer address width; must satisfy WPL <= 2^LB_AW.

Ports:
- i_clk  in  1  pixel clock
- i_rstn  in  1  reset
- i_fetch_start  in  1  one-cycle pulse: begin fetching line i_fetch_line
- i_fetch_line  in  10  line to fetch; sampled only when i_fetch_start=1
- i_wr_valid  in  1  host write request
- o_wr_ready  out  1  host write accepted this cycle
- i_wr_addr  in  ADDR_W  host word address
- i_wr_data  in  DATA_W  host write data
- o_mem_en  out  1  RAM access strobe (combinational)
- o_mem_we  out  1  RAM write enable (combinational)
- o_mem_addr  out  ADDR_W  RAM address (combinational)
- o_mem_wdata  out  DATA_W  RAM write data (combinational)
- i_mem_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after a read strobe
- o_lb_we  out  1  line-buffer write strobe (registered)
- o_lb_addr  out  LB_AW  line-buffer word index (registered)
- o_lb_wdata  out  DATA_W  line-buffer data (registered)
- o_lb_bank  out  1  bank currently being filled; the display reads the other bank
- o_busy  out  1  fetch in progress (state != IDLE)
- o_overrun  out  1  one-cycle pulse: i_fetch_start arrived while busy

Behaviour:
- Reset is i_rstn, asynchronous, active-low; clock is i_clk.
- Reset values:
  - state = IDLE; o_lb_bank = 0.
  - Word counter, line base and fetch-valid pipeline cleared.
  - All registered outputs 0.
  - o_wr_ready = 0 and o_mem_en = 0 while i_rstn = 0.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - i_fetch_start=1 and i_fetch_line < LINES: latch base = i_fetch_line*WPL (constant multiply, ADDR_W bits), clear word count k, go to FETCH.
  - i_fetch_start=1 and i_fetch_line >= LINES: ignored; stay IDLE; no overrun.
- FETCH:
  - Each cycle: o_mem_en=1, o_mem_we=0, o_mem_addr = base + k.
  - When k = WPL-1, go to DRAIN; otherwise k++.
  - Exactly WPL consecutive read cycles, no gaps.
- DRAIN:
  - Single cycle; the last read data returns.
  - Next state IDLE; o_lb_bank toggles on the DRAIN->IDLE edge.
- Line-buffer write path:
  - A read issued at cycle t gives o_lb_we=1, o_lb_addr=k(t), o_lb_wdata=i_mem_rdata at cycle t+1.
  - Implemented with a 1-stage valid/index pipeline.
  - The last lb write coincides with DRAIN.
- Timing: first lb write occurs 2 cycles after the i_fetch_start pulse; o_busy is high for WPL+1 cycles.
- Host write port:
  - o_wr_ready = (state==IDLE) && !i_fetch_start. A fetch start wins a same-cycle tie.
  - Transfer occurs when i_wr_valid && o_wr_ready.
  - On transfer: o_mem_en=1, o_mem_we=1, o_mem_addr=i_wr_addr, o_mem_wdata=i_wr_data, all in the same cycle.
  - Out-of-range write (i_wr_addr >= LINES*WPL): o_wr_ready still accepts it, but o_mem_en=0 (write dropped).
- Overrun: i_fetch_start in FETCH or DRAIN pulses o_overrun for 1 cycle. The request is discarded and the current fetch continues unchanged.
- Idle RAM: when no request is active, o_mem_en=0.
- Reset mid-fetch: immediate return to IDLE with bank=0. A partial line in the buffer is not flagged.

Decomposition:
- Package dvi_pkg holds:
  - WPL, LINES, ADDR_W, DATA_W, LB_AW defaults.
  - FSM state encoding (2-bit IDLE/FETCH/DRAIN).
  - Helper constant FB_WORDS = LINES*WPL.
- No sub-module required. The line-base multiplier is inline (shift-add for WPL=160: (line<<7)+(line<<5)).

Test Plan:
- Fetch line 0 after reset:
  - Stimulus: i_fetch_start with line=0; RAM model returns addr as data.
  - Required: 160 reads at addresses 0..159; lb writes idx 0..159 with data 0..159 starting 2 cycles after start; o_busy high 161 cycles; o_lb_bank 0->1 afterwards.
- Fetch line 479 (last line):
  - Required: reads at addresses 76640..76799.
  - Then fetch line 480: no RAM activity, o_busy stays 0, o_overrun stays 0.
- Host contention:
  - Stimulus: i_wr_valid held high continuously; fetch start issued mid-stream.
  - Required: o_wr_ready=0 from the fetch-start cycle through DRAIN; every accepted write appears on RAM with we=1 at the given addr; no write lost or duplicated.
- Overrun:
  - Stimulus: second i_fetch_start 50 cycles into a fetch.
  - Required: o_overrun pulses 1 cycle; the original fetch completes all 160 words; bank toggles once only.
- Out-of-range host write:
  - Stimulus: i_wr_addr=76800.
  - Required: o_wr_ready=1 and o_mem_en=0.
- Reset mid-fetch:
  - Stimulus: i_rstn low at word 80.
  - Required: all outputs 0 immediately; bank=0; a new fetch after release starts cleanly at word 0.
